// File: rtl/uart_pkg.sv
// uart_pkg: types and defaults shared by the UART receive and transmit blocks.
package uart_pkg;

    // Default bit period: 50 MHz system clock, 115200 baud.
    localparam int UART_CLK_DIV   = 434;
    localparam int UART_MAX_BYTES = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // A word length of zero or one beyond the word buffer means "full word".
    function automatic logic [3:0] clamp_len(input logic [3:0] len_in, input logic [3:0] max_len);
        return (len_in == 4'd0 || len_in > max_len) ? max_len : len_in;
    endfunction

endpackage

// File: rtl/rx_bps_module.sv
// rx_bps_module: receive bit-timing counter. A start pulse arms it; the first
// sample pulse lands half a bit later (mid start bit), then one per full bit
// period for as long as enable stays high.
module rx_bps_module
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic enable,
    output logic sample
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count down to zero; zero while enabled is a sample point, then reload a full period.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = HALF_M1;
        end else if (enable) begin
            cnt_d = (cnt_q == '0) ? FULL_M1 : cnt_q - 1'b1;
        end
    end

    // Bit-period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample = enable && (cnt_q == '0);

endmodule

// File: rtl/rx_control_module.sv
// rx_control_module: 8N1 UART receiver that assembles `len` bytes into one
// right-aligned word, first byte most significant, and strobes rx_done.
// Optional build macro RX_TIMEOUT_EN adds an inter-byte idle timeout.
module rx_control_module
    import uart_pkg::*;
#(
    parameter int CLK_DIV      = UART_CLK_DIV,
    parameter int MAX_BYTES    = UART_MAX_BYTES,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_pin_in,
    input  logic [3:0]             len,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic                   rx_done,
    output logic                   rx_busy,
    output logic                   frame_err,
    output logic                   rx_timeout
);
    localparam int         WORD_W  = 8 * MAX_BYTES;
    localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

    if (CLK_DIV < 8 || (CLK_DIV % 2) != 0 || MAX_BYTES < 1 || MAX_BYTES > 15 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("rx_control_module: CLK_DIV must be even and >= 8, MAX_BYTES 1..15, TIMEOUT_BITS >= 1");
    end

    logic              sync1_q, sync2_q, line_prev_q;
    logic              line, fall;
    rx_state_t         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    byte_t             shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d, word_shift;
    logic [3:0]        remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              sample, bps_start, bps_enable;

`ifdef RX_TIMEOUT_EN
    localparam int            TO_LIMIT = TIMEOUT_BITS * CLK_DIV;
    localparam int            TO_W     = $clog2(TO_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    assign line       = sync2_q;
    assign fall       = line_prev_q & ~sync2_q;
    assign bps_enable = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign word_shift = WORD_W'({word_q, shift_q});

    rx_bps_module #(
        .CLK_DIV (CLK_DIV)
    ) u_bps (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (bps_start),
        .enable (bps_enable),
        .sample (sample)
    );

    // Receive state machine and word assembly.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        data_d      = data_q;
        done_d      = 1'b0;
        ferr_d      = 1'b0;
        bps_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d   = START;
                    bps_start = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    if (!line) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                        // Word length is latched only by the first byte of a word.
                        if (!busy_q) begin
                            remaining_d = clamp_len(len, MAX_LEN);
                            busy_d      = 1'b1;
                        end
                    end else begin
                        // Line back high at mid start bit: noise, keep any partial word.
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {line, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (line) begin
                        state_d = IDLE;
                        if (remaining_q == 4'd1) begin
                            data_d      = word_shift;
                            done_d      = 1'b1;
                            busy_d      = 1'b0;
                            word_d      = '0;
                            remaining_d = 4'd0;
                        end else begin
                            word_d      = word_shift;
                            remaining_d = remaining_q - 4'd1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        busy_d  = 1'b0;
                        word_d  = '0;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must return high before a new frame can start.
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef RX_TIMEOUT_EN
        timeout_d  = 1'b0;
        idle_cnt_d = '0;
        if (state_q == IDLE && busy_q && !fall) begin
            if (idle_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                busy_d    = 1'b0;
                word_d    = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Synchronizer, edge history, FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            word_q      <= '0;
            remaining_q <= 4'd0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sync1_q     <= rx_pin_in;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
        end
    end

    // Byte shift register carries only data and needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

`ifdef RX_TIMEOUT_EN
    // Inter-byte idle counter and timeout strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rx_timeout = timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_rx_control_module.sv
// tb_rx_control_module: drives serial frames into rx_control_module and checks
// words, strobes and timing against a byte-list word model.
`timescale 1ns/1ps
module tb_rx_control_module;
    localparam int CLK_DIV      = 16;
    localparam int MAX_BYTES    = 8;
    localparam int TIMEOUT_BITS = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_pin_in;
    logic [3:0]  len;
    logic [63:0] rx_data;
    logic        rx_done, rx_busy, frame_err, rx_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    int done_cnt = 0, ferr_cnt = 0, to_cnt = 0, busy_cnt = 0;
    int done_cyc = 0, to_cyc = 0;
    int last_start = 0;
    logic [7:0]  bytes_a [16];
    logic [63:0] model_word = 64'h0;

    rx_control_module #(
        .CLK_DIV      (CLK_DIV),
        .MAX_BYTES    (MAX_BYTES),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_pin_in  (rx_pin_in),
        .len        (len),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .rx_timeout (rx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_done)    begin done_cnt++; done_cyc = edge_n; end
        if (frame_err)  ferr_cnt++;
        if (rx_timeout) begin to_cnt++; to_cyc = edge_n; end
        if (rx_busy)    busy_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int eff_len(input int l);
        return (l == 0 || l > MAX_BYTES) ? MAX_BYTES : l;
    endfunction

    task automatic drive_bit(input logic b);
        rx_pin_in = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = edge_n;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // Send bytes_a[0..n-1] as one word; the model word is the bytes concatenated in send order.
    task automatic send_word(input int l, input int n);
        logic [63:0] exp;
        int d0, f0;
        exp = 64'h0;
        for (int i = 0; i < n; i++) exp = (exp << 8) | 64'(bytes_a[i]);
        d0 = done_cnt;
        f0 = ferr_cnt;
        len = 4'(l);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes_a[i], 1'b1);
            if (i == 0) len = 4'($urandom_range(0, 15));
            if (i < n - 1) check_eq("busy_mid_word", 64'(rx_busy), 64'h1);
        end
        drive_bit(1'b1);
        check_eq("done_count", 64'(done_cnt - d0), 64'h1);
        check_eq("word_data", rx_data, exp);
        check_eq("no_frame_err", 64'(ferr_cnt - f0), 64'h0);
        model_word = exp;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"}, rx_data, 64'h0);
        check_eq({tag, "_done"}, 64'(rx_done), 64'h0);
        check_eq({tag, "_busy"}, 64'(rx_busy), 64'h0);
        check_eq({tag, "_ferr"}, 64'(frame_err), 64'h0);
        check_eq({tag, "_timeout"}, 64'(rx_timeout), 64'h0);
    endtask

    initial begin
        int d0, f0, b0, t0, sb, lo, hi;
        rst_n = 1'b0;
        rx_pin_in = 1'b1;
        len = 4'd1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_bit(1'b1);

        // Single byte, with strobe timing.
        bytes_a[0] = 8'hA5;
        send_word(1, 1);
        check_eq("done_time", 64'(done_cyc), 64'(last_start + 2 + CLK_DIV/2 + 9*CLK_DIV + 1));

        // Four bytes back-to-back.
        bytes_a[0] = 8'h12; bytes_a[1] = 8'h34; bytes_a[2] = 8'h56; bytes_a[3] = 8'h78;
        send_word(4, 4);
        check_eq("len4_word", model_word, 64'h0000_0000_1234_5678);

        // len = 0 means a full eight-byte word.
        for (int i = 0; i < 8; i++) bytes_a[i] = 8'(i + 1);
        send_word(0, 8);

        // Short low glitch is a false start.
        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        rx_pin_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_eq("glitch_busy", 64'(busy_cnt - b0), 64'h0);
        check_eq("glitch_done", 64'(done_cnt - d0), 64'h0);
        check_eq("glitch_ferr", 64'(ferr_cnt - f0), 64'h0);
        bytes_a[0] = 8'h3C;
        send_word(1, 1);

        // Bad stop bit, then a long break, then a good frame.
        d0 = done_cnt; f0 = ferr_cnt;
        len = 4'd1;
        send_byte(8'h55, 1'b0);
        b0 = busy_cnt;
        repeat (40 * CLK_DIV) @(posedge clk);
        #1;
        check_eq("break_ferr", 64'(ferr_cnt - f0), 64'h1);
        check_eq("break_done", 64'(done_cnt - d0), 64'h0);
        check_eq("break_busy", 64'(busy_cnt - b0), 64'h0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        bytes_a[0] = 8'h99;
        send_word(1, 1);

        // Partial word followed by a long idle gap.
        d0 = done_cnt; t0 = to_cnt;
        len = 4'd2;
        send_byte(8'hAB, 1'b1);
        sb = last_start;
        len = 4'd1;
        repeat (25) drive_bit(1'b1);
`ifdef RX_TIMEOUT_EN
        check_eq("timeout_count", 64'(to_cnt - t0), 64'h1);
        lo = sb + 2 + CLK_DIV/2 + 9*CLK_DIV + TIMEOUT_BITS*CLK_DIV - 1;
        hi = lo + 4;
        check_eq("timeout_window", 64'((to_cyc >= lo) && (to_cyc <= hi)), 64'h1);
        check_eq("timeout_data_kept", rx_data, model_word);
        check_eq("timeout_busy", 64'(rx_busy), 64'h0);
        check_eq("timeout_no_done", 64'(done_cnt - d0), 64'h0);
        bytes_a[0] = 8'h5A;
        send_word(1, 1);
`else
        check_eq("no_timeout", 64'(to_cnt - t0), 64'h0);
        check_eq("partial_waits_busy", 64'(rx_busy), 64'h1);
        check_eq("partial_no_done", 64'(done_cnt - d0), 64'h0);
        send_byte(8'hCD, 1'b1);
        drive_bit(1'b1);
        check_eq("late_byte_done", 64'(done_cnt - d0), 64'h1);
        check_eq("late_byte_word", rx_data, 64'h0000_0000_0000_ABCD);
        model_word = 64'hABCD;
`endif

        // Reset in the middle of the second byte of a two-byte word.
        len = 4'd2;
        send_byte(8'hEE, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rx_pin_in = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        bytes_a[0] = 8'hC3;
        send_word(1, 1);

        // Random words, random lengths, random idle gaps, len changed mid-word.
        for (int w = 0; w < 10; w++) begin
            int l, n, gap;
            l = $urandom_range(0, 15);
            n = eff_len(l);
            for (int i = 0; i < n; i++) bytes_a[i] = 8'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
            send_word(l, n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
